cfg_spi_regs: RTL and testbench

Configuration SPI slave and register bank for the PID controller. Sits directly upstream of the PID core, strobe generator and SPI masters: it receives byte frames from an external host on the cfg_* pins and holds four 8-bit configuration registers. It presents them as a 32-bit configuration word that is updated atomically at the end of each valid frame. The word supplies setpoint, gains and strobe period.

---
 rtl/cfg_pkg.sv | 11 +
 rtl/sync_edge.sv | 37 +++
 rtl/cfg_spi_regs.sv | 177 +++++++++++++++++
 tb/tb_cfg_spi_regs.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared constants, state encoding and register-bank type for the configuration SPI slave.
package cfg_pkg;
    localparam int          CMD_WRITE_BIT = 7;
    localparam int          ADDR_W        = 2;
    localparam int          NUM_REGS      = 4;
    localparam logic [31:0] DEFAULT_CFG   = 32'h1000_234A;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DROP} state_e;

    typedef logic [NUM_REGS-1:0][7:0] bank_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with an edge register producing
// single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/cfg_spi_regs.sv
// Configuration SPI slave (mode 0) with a shadow/active register bank committed atomically
// at frame end. Read-back over cfg_miso is built only when CFG_READBACK_EN is defined.
module cfg_spi_regs
    import cfg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_cs,
    input  logic        cfg_sck,
    input  logic        cfg_mosi,
    output logic        cfg_miso,
    output logic [31:0] cfg_out,
    output logic        cfg_update,
    output logic        frame_err
);
    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(reset), .d(cfg_cs), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(reset), .d(cfg_sck), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(reset), .d(cfg_mosi), .lvl(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    logic unused_sync;
    assign unused_sync = ^{cs_lvl, sck_lvl, mosi_rise, mosi_fall};

    state_e            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wbyte_q, wbyte_d;
    bank_t             shadow_q, shadow_d;
    bank_t             active_q, active_d;
    logic              update_q, update_d;
    logic              err_q, err_d;
`ifdef CFG_READBACK_EN
    logic [7:0]        tx_q, tx_d;
    logic              first_q, first_d;
`endif

    logic [7:0] cmd_byte;
    logic       byte_done;
    assign cmd_byte  = {shift_q[6:0], mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // cs rise wins over any coincident sck edge: the frame simply ends.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: if (byte_done) begin
                    if (|cmd_byte[6:2])              state_d = DROP;
                    else if (cmd_byte[CMD_WRITE_BIT]) state_d = WDATA;
                    else                              state_d = RDATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        wbyte_d   = wbyte_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
`ifdef CFG_READBACK_EN
        tx_d      = tx_q;
        first_d   = first_q;
`endif
        if (cs_rise) begin
            bit_cnt_d = 3'd0;
            if (state_q == WDATA) begin
                if (bit_cnt_q != 3'd0) begin
                    err_d = 1'b1;
                end else if (wbyte_q) begin
                    active_d = shadow_q;
                    update_d = 1'b1;
                end
            end else if (state_q == DROP) begin
                err_d = 1'b1;
            end
        end else begin
            if (state_q == IDLE && cs_fall) begin
                shadow_d  = active_q;
                bit_cnt_d = 3'd0;
                wbyte_d   = 1'b0;
            end
            if (state_q != IDLE && sck_rise) begin
                shift_d   = cmd_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done && state_q == CMD)
                addr_d = cmd_byte[ADDR_W-1:0];
            if (byte_done && state_q == WDATA) begin
                shadow_d[addr_q] = cmd_byte;
                addr_d           = addr_q + 2'd1;
                wbyte_d          = 1'b1;
            end
`ifdef CFG_READBACK_EN
            if (byte_done && state_q == CMD && !cmd_byte[CMD_WRITE_BIT] && !(|cmd_byte[6:2])) begin
                tx_d    = active_q[cmd_byte[ADDR_W-1:0]];
                addr_d  = cmd_byte[ADDR_W-1:0] + 2'd1;
                first_d = 1'b1;
            end
            // The first fall after the command byte closes its last bit; the byte is already loaded.
            if (state_q == RDATA && sck_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        tx_d   = active_q[addr_q];
                        addr_d = addr_q + 2'd1;
                    end
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wbyte_q   <= 1'b0;
            shadow_q  <= DEFAULT_CFG;
            active_q  <= DEFAULT_CFG;
            update_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef CFG_READBACK_EN
            tx_q      <= '0;
            first_q   <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wbyte_q   <= wbyte_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            update_q  <= update_d;
            err_q     <= err_d;
`ifdef CFG_READBACK_EN
            tx_q      <= tx_d;
            first_q   <= first_d;
`endif
        end
    end

    always_comb begin
        cfg_out    = active_q;
        cfg_update = update_q;
        frame_err  = err_q;
`ifdef CFG_READBACK_EN
        cfg_miso   = (state_q == RDATA) ? tx_q[7] : 1'b0;
`else
        cfg_miso   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_cfg_spi_regs.sv
// Directed bench for cfg_spi_regs: bit-banged SPI frames with hand-computed register images.
module tb_cfg_spi_regs;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_cs, cfg_sck, cfg_mosi;
    logic        cfg_miso;
    logic [31:0] cfg_out;
    logic        cfg_update, frame_err;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int stray = 0;
    int u0, e0;
    logic [31:0] prev_cfg;
    logic [7:0]  rx, rx0, rx1;

    cfg_spi_regs dut (
        .clk(clk), .reset(reset), .cfg_cs(cfg_cs), .cfg_sck(cfg_sck), .cfg_mosi(cfg_mosi),
        .cfg_miso(cfg_miso), .cfg_out(cfg_out), .cfg_update(cfg_update), .frame_err(frame_err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) upd_cnt++;
        if (frame_err === 1'b1)  err_cnt++;
        if (reset === 1'b1 && cfg_out !== prev_cfg && cfg_update !== 1'b1) stray++;
        prev_cfg = cfg_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            cfg_mosi = b[7-i];
            wait_clk(H);
            r[7-i] = cfg_miso;
            cfg_sck = 1'b1;
            wait_clk(H);
            cfg_sck = 1'b0;
        end
    endtask

    task automatic start_frame();
        u0 = upd_cnt;
        e0 = err_cnt;
        cfg_cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic end_frame(input string tag, input int exp_upd, input int exp_err,
                             input logic [31:0] exp_cfg);
        wait_clk(H);
        cfg_cs = 1'b1;
        wait_clk(10);
        check({tag, "_upd"}, 32'(upd_cnt - u0), 32'(exp_upd));
        check({tag, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
        check({tag, "_cfg"}, cfg_out, exp_cfg);
    endtask

    initial begin
        reset = 1'b0; cfg_cs = 1'b1; cfg_sck = 1'b0; cfg_mosi = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(5);
        check("rst_cfg", cfg_out, 32'h1000_234A);
        check("rst_upd", {31'd0, cfg_update}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_miso", {31'd0, cfg_miso}, 32'd0);

        // read from addr 1, two bytes
        start_frame();
        send_bits(8'h01, 8, rx);
        check("rd_cmd_miso", {24'd0, rx}, 32'd0);
        send_bits(8'h00, 8, rx0);
        send_bits(8'h00, 8, rx1);
`ifdef CFG_READBACK_EN
        check("rd_byte0", {24'd0, rx0}, 32'h23);
        check("rd_byte1", {24'd0, rx1}, 32'h00);
`else
        check("rd_byte0", {24'd0, rx0}, 32'h00);
        check("rd_byte1", {24'd0, rx1}, 32'h00);
`endif
        end_frame("rd", 0, 0, 32'h1000_234A);

        start_frame();
        send_bits(8'h80, 8, rx); send_bits(8'h5C, 8, rx); send_bits(8'h71, 8, rx);
        send_bits(8'h20, 8, rx); send_bits(8'h00, 8, rx);
        end_frame("wr4", 1, 0, 32'h0020_715C);
        check("sp", {28'd0, cfg_out[3:0]}, 32'hC);
        check("kp", {28'd0, cfg_out[7:4]}, 32'h5);
        check("stb", {16'd0, cfg_out[31:16]}, 32'h0020);

        start_frame();
        send_bits(8'h83, 8, rx); send_bits(8'hAA, 8, rx); send_bits(8'hBB, 8, rx);
        end_frame("wrap3", 1, 0, 32'hAA20_71BB);

        start_frame();
        send_bits(8'h80, 8, rx); send_bits(8'h11, 8, rx); send_bits(8'hA0, 4, rx);
        end_frame("partial", 0, 1, 32'hAA20_71BB);

        start_frame();
        send_bits(8'h84, 8, rx); send_bits(8'h55, 8, rx);
        end_frame("resv", 0, 1, 32'hAA20_71BB);

        start_frame();
        send_bits(8'h80, 8, rx);
        end_frame("nodata", 0, 0, 32'hAA20_71BB);

        start_frame();
        send_bits(8'h80, 5, rx);
        end_frame("shortcmd", 0, 0, 32'hAA20_71BB);

        // reset pulled mid-frame
        start_frame();
        send_bits(8'h80, 8, rx); send_bits(8'h12, 8, rx);
        reset = 1'b0;
        wait_clk(2);
        check("midrst_cfg", cfg_out, 32'h1000_234A);
        check("midrst_upd", {31'd0, cfg_update}, 32'd0);
        cfg_cs = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(10);
        check("midrst_after", cfg_out, 32'h1000_234A);

        start_frame();
        send_bits(8'h80, 8, rx); send_bits(8'h12, 8, rx); send_bits(8'h34, 8, rx);
        end_frame("post_rst", 1, 0, 32'h1000_3412);

        start_frame();
        send_bits(8'h80, 8, rx);
        for (int i = 1; i <= 5; i++) send_bits(8'(i), 8, rx);
        end_frame("wrap5", 1, 0, 32'h0403_0205);

        check("stray_cfg_change", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
